// File: rtl/p251_pkg.sv
// Shared GF(251) definitions: field constant, modular helpers, evaluator state encoding
// and the fixed latency of the serial field multiplier.
package p251_pkg;

    localparam logic [7:0] P251    = 8'd251;
    localparam int         MUL_LAT = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_TOP,
        S_WAIT_TOP,
        S_MUL,
        S_WAIT_MUL,
        S_FINISH
    } state_t;

    // Conditional subtract: maps any 8-bit value into [0,250].
    function automatic logic [7:0] p251_reduce(input logic [7:0] v);
        return (v >= P251) ? v - P251 : v;
    endfunction

    // Modular add of two operands already in [0,250].
    function automatic logic [7:0] p251_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [8:0] d;
        s = {1'b0, a} + {1'b0, b};
        d = s - {1'b0, P251};
        return (s >= {1'b0, P251}) ? d[7:0] : s[7:0];
    endfunction

endpackage

// File: rtl/p251_mul.sv
// Pipelined GF(251) multiplier: MSB-first double-and-add, two operand bits per stage,
// MUL_LAT cycles from start to done. Operands must already lie in [0,250].
module p251_mul
    import p251_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] in_1,
    input  logic [7:0] in_2,
    input  logic       start,
    output logic [7:0] out,
    output logic       done
);

    function automatic logic [7:0] step2(input logic [7:0] acc, input logic [7:0] a,
                                         input logic [1:0] bits);
        logic [7:0] t;
        t = p251_add(acc, acc);
        if (bits[1]) t = p251_add(t, a);
        t = p251_add(t, t);
        if (bits[0]) t = p251_add(t, a);
        return t;
    endfunction

    logic [7:0] r_acc_p0, r_acc_p1, r_acc_p2, r_acc_p3;
    logic [7:0] r_a_p0, r_a_p1, r_a_p2;
    logic [5:0] r_b_p0;
    logic [3:0] r_b_p1;
    logic [1:0] r_b_p2;
    logic       r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3;

    // No reset: the valid chain flushes itself within MUL_LAT idle cycles.
    always_ff @(posedge clk) begin
        // p0: bits 7..6
        r_vld_p0 <= start;
        r_acc_p0 <= step2(8'd0, in_1, in_2[7:6]);
        r_a_p0   <= in_1;
        r_b_p0   <= in_2[5:0];
        // p1: bits 5..4
        r_vld_p1 <= r_vld_p0;
        r_acc_p1 <= step2(r_acc_p0, r_a_p0, r_b_p0[5:4]);
        r_a_p1   <= r_a_p0;
        r_b_p1   <= r_b_p0[3:0];
        // p2: bits 3..2
        r_vld_p2 <= r_vld_p1;
        r_acc_p2 <= step2(r_acc_p1, r_a_p1, r_b_p1[3:2]);
        r_a_p2   <= r_a_p1;
        r_b_p2   <= r_b_p1[1:0];
        // p3: bits 1..0
        r_vld_p3 <= r_vld_p2;
        r_acc_p3 <= step2(r_acc_p2, r_a_p2, r_b_p2);
    end

    assign out  = r_acc_p3;
    assign done = r_vld_p3;

endmodule

// File: rtl/p251_horner_eval.sv
// Horner-rule evaluator of P(x) mod 251 over coefficients fetched from external memory,
// one multiply per coefficient through p251_mul.
module p251_horner_eval
    import p251_pkg::*;
#(
    parameter int N_COEFF = 16,
    parameter int ADDR_W  = (N_COEFF > 1) ? $clog2(N_COEFF) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        x,
    output logic              coeff_rd,
    output logic [ADDR_W-1:0] coeff_addr,
    input  logic [7:0]        coeff_in,
    output logic [7:0]        result,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ADDR_TOP  = ADDR_W'(N_COEFF - 1);
    localparam logic [ADDR_W-1:0] ADDR_NEXT = ADDR_W'((N_COEFF > 1) ? N_COEFF - 2 : 0);

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_coeff_rd;
    logic [ADDR_W-1:0] r_coeff_addr;
    logic              r_mul_start;
    logic [7:0]        r_result;
    logic [ADDR_W-1:0] r_idx;
    logic              r_first;
    logic [7:0]        r_x;
    logic [7:0]        r_acc;
    logic [7:0]        r_c;

    logic [7:0] w_mul_out;
    logic       w_mul_done;
    logic [7:0] w_c_in;
    logic [7:0] w_c_sel;
    logic [7:0] w_sum;

    p251_mul u_mul (
        .clk   (clk),
        .in_1  (r_acc),
        .in_2  (r_x),
        .start (r_mul_start),
        .out   (w_mul_out),
        .done  (w_mul_done)
    );

    // The coefficient bus is only valid in the first WAIT_MUL cycle; later use the copy.
    assign w_c_in  = p251_reduce(coeff_in);
    assign w_c_sel = r_first ? w_c_in : r_c;
    assign w_sum   = p251_add(w_mul_out, w_c_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_coeff_rd   <= 1'b0;
            r_coeff_addr <= '0;
            r_mul_start  <= 1'b0;
            r_result     <= 8'd0;
            r_idx        <= '0;
            r_first      <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_coeff_rd  <= 1'b0;
            r_mul_start <= 1'b0;
            r_first     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_LOAD_TOP;
                        r_busy       <= 1'b1;
                        r_coeff_rd   <= 1'b1;
                        r_coeff_addr <= ADDR_TOP;
                    end
                end
                S_LOAD_TOP: r_state <= S_WAIT_TOP;
                S_WAIT_TOP: begin
                    if (N_COEFF == 1) begin
                        r_state  <= S_FINISH;
                        r_done   <= 1'b1;
                        r_result <= w_c_in;
                    end else begin
                        r_state      <= S_MUL;
                        r_idx        <= ADDR_NEXT;
                        r_mul_start  <= 1'b1;
                        r_coeff_rd   <= 1'b1;
                        r_coeff_addr <= ADDR_NEXT;
                    end
                end
                S_MUL: begin
                    r_state <= S_WAIT_MUL;
                    r_first <= 1'b1;
                end
                S_WAIT_MUL: begin
                    if (w_mul_done) begin
                        if (r_idx == '0) begin
                            r_state  <= S_FINISH;
                            r_done   <= 1'b1;
                            r_result <= w_sum;
                        end else begin
                            r_state      <= S_MUL;
                            r_idx        <= r_idx - ADDR_W'(1);
                            r_mul_start  <= 1'b1;
                            r_coeff_rd   <= 1'b1;
                            r_coeff_addr <= r_idx - ADDR_W'(1);
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always rewritten before use.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start)
            r_x <= p251_reduce(x);
        if (r_state == S_WAIT_TOP)
            r_acc <= w_c_in;
        if (r_state == S_WAIT_MUL && r_first)
            r_c <= w_c_in;
        if (r_state == S_WAIT_MUL && w_mul_done)
            r_acc <= w_sum;
    end

    assign coeff_rd   = r_coeff_rd;
    assign coeff_addr = r_coeff_addr;
    assign result     = r_result;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_p251_horner_eval.sv
// Bench for p251_horner_eval: four instances (N = 16, 4, 2, 1) sharing clock and reset,
// each with its own coefficient memory, checked against a power-sum reference model.
`timescale 1ns/1ps
module tb_p251_horner_eval;
    import p251_pkg::*;

    localparam int L      = MUL_LAT;
    localparam int NS [4] = '{16, 4, 2, 1};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] start = '0;
    logic [3:0] rd, busy, done;
    logic [7:0] x     [4];
    logic [7:0] cin   [4];
    logic [7:0] res   [4];
    logic [4:0] addr_w[4];
    logic [7:0] mem   [4][16];

    int cyc = 0, n_chk = 0, n_pass = 0;
    int t0[4], done_cnt[4], done_cyc[4], rd_cnt[4];
    int mul_starts;
    logic [7:0] done_res[4];
    logic [4:0] rd_hist[4][32];

    genvar g;
    for (g = 0; g < 4; g++) begin : G
        localparam int N  = NS[g];
        localparam int AW = (N > 1) ? $clog2(N) : 1;
        logic [AW-1:0] addr;
        p251_horner_eval #(.N_COEFF(N)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start[g]),
            .x          (x[g]),
            .coeff_rd   (rd[g]),
            .coeff_addr (addr),
            .coeff_in   (cin[g]),
            .result     (res[g]),
            .busy       (busy[g]),
            .done       (done[g])
        );
        assign addr_w[g] = 5'(addr);
    end

    // Coefficient memories: data one cycle after the read strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 4; k++)
            if (rd[k]) cin[k] <= mem[k][addr_w[k][3:0]];
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (done[k]) begin
                done_cnt[k]++;
                done_cyc[k] = cyc;
                done_res[k] = res[k];
            end
            if (rd[k]) begin
                if (rd_cnt[k] < 32) rd_hist[k][rd_cnt[k]] = addr_w[k];
                rd_cnt[k]++;
            end
        end
        if (G[3].dut.u_mul.start) mul_starts++;
    end

    // P(x) = sum c_i * x^i mod 251, computed directly from powers of x.
    function automatic logic [7:0] ref_eval(input int gi, input logic [7:0] xv);
        int r, pw, xr, c;
        r = 0; pw = 1; xr = int'(xv) % 251;
        for (int i = 0; i < NS[gi]; i++) begin
            c  = int'(mem[gi][i]) % 251;
            r  = (r + c * pw) % 251;
            pw = (pw * xr) % 251;
        end
        return 8'(r);
    endfunction

    task automatic clear_mon(input int gi);
        done_cnt[gi] = 0;
        rd_cnt[gi]   = 0;
        mul_starts   = 0;
    endtask

    task automatic launch(input int gi, input logic [7:0] xv);
        @(negedge clk);
        clear_mon(gi);
        x[gi]     = xv;
        start[gi] = 1'b1;
        t0[gi]    = cyc;
        @(negedge clk);
        start[gi] = 1'b0;
    endtask

    task automatic wait_done(input int gi, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (done_cnt[gi] != 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if ({res[k], done[k], busy[k], rd[k], addr_w[k]} !== 16'd0)
                $display("FAIL reset_outputs inst=%0d got res=%0d done=%b busy=%b rd=%b addr=%0d want all 0",
                         k, res[k], done[k], busy[k], rd[k], addr_w[k]);
            else n_pass++;
        end
    endtask

    task automatic test_basic;
        bit ok;
        mem[1][0] = 8'd1; mem[1][1] = 8'd2; mem[1][2] = 8'd3; mem[1][3] = 8'd4;
        launch(1, 8'd2);
        wait_done(1, 100, ok);
        #1;
        n_chk++;
        if (busy[1] !== 1'b0) $display("FAIL basic_busy_after_done got %b want 0", busy[1]);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++;
        if (!ok || done_cnt[1] != 1) $display("FAIL basic_done_count got %0d want 1", done_cnt[1]);
        else n_pass++;
        n_chk++;
        if (done_res[1] !== 8'd49) $display("FAIL basic_result got %0d want 49", done_res[1]);
        else n_pass++;
        n_chk++;
        if (res[1] !== 8'd49) $display("FAIL basic_result_held got %0d want 49", res[1]);
        else n_pass++;
        n_chk++;
        if (done_cyc[1] - t0[1] != 3 + 3 * (1 + L))
            $display("FAIL basic_latency got %0d want %0d", done_cyc[1] - t0[1], 3 + 3 * (1 + L));
        else n_pass++;
        n_chk++;
        if (rd_cnt[1] != 4 || {rd_hist[1][0], rd_hist[1][1], rd_hist[1][2], rd_hist[1][3]} !==
            {5'd3, 5'd2, 5'd1, 5'd0})
            $display("FAIL basic_reads got n=%0d addrs=%0d,%0d,%0d,%0d want n=4 addrs=3,2,1,0",
                     rd_cnt[1], rd_hist[1][0], rd_hist[1][1], rd_hist[1][2], rd_hist[1][3]);
        else n_pass++;
    endtask

    task automatic test_x_zero;
        bit ok;
        mem[1][0] = 8'd17;
        for (int i = 1; i < 4; i++) mem[1][i] = 8'($urandom_range(0, 255));
        launch(1, 8'd0);
        wait_done(1, 100, ok);
        n_chk++;
        if (!ok || done_res[1] !== 8'd17) $display("FAIL x_zero got %0d want 17", done_res[1]);
        else n_pass++;
    endtask

    task automatic test_wrap;
        bit ok;
        mem[2][0] = 8'd250; mem[2][1] = 8'd250;
        launch(2, 8'd250);
        wait_done(2, 100, ok);
        n_chk++;
        if (!ok || done_res[2] !== 8'd0) $display("FAIL wrap_result got %0d want 0", done_res[2]);
        else n_pass++;
        n_chk++;
        if (done_cyc[2] - t0[2] != 3 + (1 + L))
            $display("FAIL wrap_latency got %0d want %0d", done_cyc[2] - t0[2], 3 + (1 + L));
        else n_pass++;
    endtask

    task automatic test_reduce;
        bit ok;
        mem[3][0] = 8'd255;
        launch(3, 8'($urandom_range(0, 255)));
        wait_done(3, 100, ok);
        repeat (2) @(negedge clk);
        n_chk++;
        if (!ok || done_res[3] !== 8'd4) $display("FAIL reduce_result got %0d want 4", done_res[3]);
        else n_pass++;
        n_chk++;
        if (done_cyc[3] - t0[3] != 3) $display("FAIL reduce_latency got %0d want 3", done_cyc[3] - t0[3]);
        else n_pass++;
        n_chk++;
        if (mul_starts != 0 || rd_cnt[3] != 1)
            $display("FAIL reduce_no_mul got mul_starts=%0d reads=%0d want 0 and 1", mul_starts, rd_cnt[3]);
        else n_pass++;
    endtask

    task automatic test_start_while_busy;
        bit ok;
        logic [7:0] want;
        for (int i = 0; i < 4; i++) mem[1][i] = 8'($urandom_range(0, 255));
        want = ref_eval(1, 8'd9);
        launch(1, 8'd9);
        @(negedge clk); start[1] = 1'b1; x[1] = 8'd77;
        @(negedge clk); start[1] = 1'b0;
        repeat (4) @(negedge clk);
        start[1] = 1'b1;
        @(negedge clk); start[1] = 1'b0;
        wait_done(1, 100, ok);
        repeat (2 * (3 + 3 * (1 + L))) @(negedge clk);
        n_chk++;
        if (!ok || done_cnt[1] != 1) $display("FAIL busy_start_done_count got %0d want 1", done_cnt[1]);
        else n_pass++;
        n_chk++;
        if (done_res[1] !== want) $display("FAIL busy_start_result got %0d want %0d", done_res[1], want);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        bit ok;
        mem[2][0] = 8'd1; mem[2][1] = 8'd1;
        launch(2, 8'd5);
        wait_done(2, 100, ok);
        n_chk++;
        if (!ok || done_res[2] !== 8'd6) $display("FAIL rstmid_pre_result got %0d want 6", done_res[2]);
        else n_pass++;
        launch(2, 8'd7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({res[2], done[2], busy[2], rd[2], addr_w[2]} !== 16'd0)
            $display("FAIL rstmid_outputs got res=%0d done=%b busy=%b rd=%b addr=%0d want all 0",
                     res[2], done[2], busy[2], rd[2], addr_w[2]);
        else n_pass++;
        repeat (L + 1) @(negedge clk);
        rst_n = 1'b1;
        clear_mon(2);
        repeat (20) @(negedge clk);
        n_chk++;
        if (done_cnt[2] != 0 || rd_cnt[2] != 0)
            $display("FAIL rstmid_quiet got done=%0d reads=%0d want 0 and 0", done_cnt[2], rd_cnt[2]);
        else n_pass++;
        launch(2, 8'd3);
        wait_done(2, 100, ok);
        n_chk++;
        if (!ok || done_res[2] !== 8'd4) $display("FAIL rstmid_fresh got %0d want 4", done_res[2]);
        else n_pass++;
    endtask

    task automatic test_random_back_to_back;
        bit ok;
        logic [7:0] xv, want;
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 16; i++) mem[0][i] = 8'($urandom_range(0, 255));
            xv   = 8'($urandom_range(0, 255));
            want = ref_eval(0, xv);
            launch(0, xv);
            wait_done(0, 200, ok);
            n_chk++;
            if (!ok || done_res[0] !== want)
                $display("FAIL random_result run=%0d x=%0d got %0d want %0d", n, xv, done_res[0], want);
            else n_pass++;
            n_chk++;
            if (done_cyc[0] - t0[0] != 3 + 15 * (1 + L))
                $display("FAIL random_latency run=%0d got %0d want %0d", n, done_cyc[0] - t0[0],
                         3 + 15 * (1 + L));
            else n_pass++;
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            x[k] = 8'd0;
            done_cnt[k] = 0;
            rd_cnt[k] = 0;
        end
        mul_starts = 0;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_reset;
        test_basic;
        test_x_zero;
        test_wrap;
        test_reduce;
        test_start_while_busy;
        test_reset_mid;
        test_random_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
